// File: rtl/csla_pipe_adder.sv
// csla_pipe_adder: pipelined carry-select adder/subtractor.
//   The WIDTH-bit operands are cut into NSEG = WIDTH/BLOCK segments. Every
//   segment forms a sum/carry pair for carry-in 0 and for carry-in 1 as soon as
//   the operands arrive. Segment k is resolved (its pair selected by the running
//   carry) in stage (k*STAGES)/NSEG. Unresolved pairs and the running carry
//   travel through the stage registers; the last register holds the result.
//   Latency is STAGES cycles, throughput one result per cycle, and a
//   valid/ready handshake with bubble squeezing is supported.
//   Requires WIDTH % BLOCK == 0 and 1 <= STAGES <= NSEG.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   i_valid, o_ready  operand handshake (o_ready is combinational from i_ready)
//   i_a, i_b          operands
//   i_cin             carry-in (borrow-in when subtracting)
//   i_sub             0 = add, 1 = subtract
//   o_valid, i_ready  result handshake
//   o_sum             WIDTH+1-bit result, bit WIDTH = carry-out
//   o_ovf             signed overflow of the WIDTH-bit result; present only
//                     when the macro CSLA_PIPE_OVF_EN is defined
module csla_pipe_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BLOCK  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_sum
`ifdef CSLA_PIPE_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  localparam int unsigned NSEG = WIDTH / BLOCK;
  localparam int unsigned SEGW = BLOCK + 1;

  // Stage that selects segment k's precomputed pair.
  function automatic int unsigned seg_stage(input int unsigned k);
    return (k * STAGES) / NSEG;
  endfunction

  // Effective operands: subtract is A + ~B + 1, with the carry-in acting as borrow.
  logic [WIDTH-1:0] b_eff;
  logic             c_first;

  assign b_eff   = i_sub ? ~i_b : i_b;
  assign c_first = i_cin ^ i_sub;

  // Handshake: valid_q[s] marks the register after stage s as occupied.
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] ld;

  // ready_s = ~valid_s | ready_(s+1), unrolled into a running OR from the output
  // side so that no signal depends on itself.
  always_comb begin : p_flow
    logic acc;
    acc     = i_ready;
    rdy     = '0;
    v_in    = '0;
    v_in[0] = i_valid;
    for (int s = 1; s < int'(STAGES); s++) begin
      v_in[s] = valid_q[s-1];
    end
    for (int s = int'(STAGES) - 1; s >= 0; s--) begin
      acc    = acc | ~valid_q[s];
      rdy[s] = acc;
    end
    ld = rdy & v_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= (valid_q & ~rdy) | (v_in & rdy);
    end
  end

  assign o_ready = rdy[0] & ~reset;
  assign o_valid = valid_q[STAGES-1];

  for (genvar s = 0; s < int'(STAGES); s++) begin : g_stage
    localparam int unsigned STAGE_IDX = s;

    // Stage inputs: per-segment pairs plus the carry into the first unresolved segment.
    logic [NSEG-1:0][BLOCK-1:0] in_s0;
    logic [NSEG-1:0][BLOCK-1:0] in_s1;
    logic [NSEG-1:0]            in_c0;
    logic [NSEG-1:0]            in_c1;
    logic                       in_cy;
    // Stage outputs: resolved segments are merged into the sum0 lanes.
    logic [NSEG-1:0][BLOCK-1:0] rs_s0;
    logic                       rs_cy;
`ifdef CSLA_PIPE_OVF_EN
    logic                       in_x;   // A[MSB] ^ B'[MSB], recovers the carry into the MSB
`endif

    if (s == 0) begin : g_src
      // Both candidate sums of every segment, straight from the operands.
      always_comb begin
        in_s0 = '0;
        in_s1 = '0;
        in_c0 = '0;
        in_c1 = '0;
        for (int unsigned k = 0; k < NSEG; k++) begin
          {in_c0[k], in_s0[k]} = SEGW'(i_a[k*BLOCK +: BLOCK]) + SEGW'(b_eff[k*BLOCK +: BLOCK]);
          {in_c1[k], in_s1[k]} = SEGW'(i_a[k*BLOCK +: BLOCK]) + SEGW'(b_eff[k*BLOCK +: BLOCK])
                                 + SEGW'(1);
        end
        in_cy = c_first;
      end
`ifdef CSLA_PIPE_OVF_EN
      assign in_x = i_a[WIDTH-1] ^ b_eff[WIDTH-1];
`endif
    end else begin : g_reg
      // Pipeline register between stage s-1 and stage s.
      always_ff @(posedge clock) begin
        if (reset) begin
          in_s0 <= '0;
          in_s1 <= '0;
          in_c0 <= '0;
          in_c1 <= '0;
          in_cy <= 1'b0;
`ifdef CSLA_PIPE_OVF_EN
          in_x  <= 1'b0;
`endif
        end else if (ld[s-1]) begin
          in_s0 <= g_stage[s-1].rs_s0;
          in_s1 <= g_stage[s-1].in_s1;
          in_c0 <= g_stage[s-1].in_c0;
          in_c1 <= g_stage[s-1].in_c1;
          in_cy <= g_stage[s-1].rs_cy;
`ifdef CSLA_PIPE_OVF_EN
          in_x  <= g_stage[s-1].in_x;
`endif
        end
      end
    end

    // Select this stage's segments in ascending order, rippling the carry.
    always_comb begin : p_resolve
      logic cy;
      rs_s0 = in_s0;
      cy    = in_cy;
      for (int unsigned k = 0; k < NSEG; k++) begin
        if (seg_stage(k) == STAGE_IDX) begin
          rs_s0[k] = cy ? in_s1[k] : in_s0[k];
          cy       = cy ? in_c1[k] : in_c0[k];
        end
      end
      rs_cy = cy;
    end
  end

  // Output register holds the fully selected sum.
  always_ff @(posedge clock) begin
    if (reset) begin
      o_sum <= '0;
`ifdef CSLA_PIPE_OVF_EN
      o_ovf <= 1'b0;
`endif
    end else if (ld[STAGES-1]) begin
      o_sum <= {g_stage[STAGES-1].rs_cy, g_stage[STAGES-1].rs_s0};
`ifdef CSLA_PIPE_OVF_EN
      // carry into MSB = A^B'^S at the MSB; overflow = that XOR carry-out
      o_ovf <= g_stage[STAGES-1].in_x ^ g_stage[STAGES-1].rs_s0[NSEG-1][BLOCK-1]
               ^ g_stage[STAGES-1].rs_cy;
`endif
    end
  end

endmodule

// File: tb/tb_csla_pipe_adder.sv
// tb_csla_pipe_adder: randomized and directed checks of csla_pipe_adder
// against an arithmetic reference model; the WIDTH=32/BLOCK=4 sweep instances
// cover STAGES=1..8. o_ovf is checked when CSLA_PIPE_OVF_EN is defined.
module tb_csla_pipe_adder;

  localparam int unsigned W    = 32;
  localparam int unsigned ST   = 2;
  localparam int          SW_N = 24;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_cin;
  logic         i_sub;
  logic         o_valid;
  logic         i_ready;
  logic [W:0]   o_sum;
`ifdef CSLA_PIPE_OVF_EN
  logic         o_ovf;
`endif

  csla_pipe_adder #(.WIDTH(W), .BLOCK(8), .STAGES(ST)) u_dut (
    .clock   (clock),
    .reset   (reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_cin   (i_cin),
    .i_sub   (i_sub),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum)
`ifdef CSLA_PIPE_OVF_EN
    ,
    .o_ovf   (o_ovf)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; returns {ovf, carry/no-borrow, sum}.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic sub);
    logic [63:0] u;
    longint      sa, sb, r, lmax, lmin;
    logic        ovf;
    if (!sub) u = 64'(a) + 64'(b) + 64'(cin);
    else      u = 64'h1_0000_0000 + 64'(a) - 64'(b) - 64'(cin);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    r    = sub ? (sa - sb - longint'(cin)) : (sa + sb + longint'(cin));
    lmax = 2147483647;
    lmin = -lmax - 1;
    ovf  = (r > lmax) || (r < lmin);
    return {ovf, u[W:0]};
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Scoreboard state for the main DUT.
  logic [W+1:0] exp_q[$];
  int           occ;
  int           n_got;
  logic         prev_stall;
  logic [W:0]   prev_sum;

  // One handshake cycle: called at edge+1 with inputs driven; samples at edge+2.
  task automatic cycle_step(output logic accepted);
    logic         drained;
    logic [W+1:0] e;
    #1;
    check_eq("o_ready", 64'(o_ready), 64'((occ < int'(ST)) || i_ready));
    if (prev_stall) begin
      check_eq("stall_valid", 64'(o_valid), 64'(1));
      check_eq("stall_sum", 64'(o_sum), 64'(prev_sum));
    end
    accepted = i_valid && o_ready;
    drained  = o_valid && i_ready;
    if (drained) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_result", 64'(o_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        n_got++;
        check_eq("stream_sum", 64'(o_sum), 64'(e[W:0]));
`ifdef CSLA_PIPE_OVF_EN
        check_eq("stream_ovf", 64'(o_ovf), 64'(e[W+1]));
`endif
      end
    end
    if (accepted) exp_q.push_back(ref_model(i_a, i_b, i_cin, i_sub));
    occ        = occ + int'(accepted) - int'(drained);
    prev_stall = o_valid && !i_ready;
    prev_sum   = o_sum;
    @(posedge clock);
    #1;
  endtask

  task automatic drive_junk();
    i_a   = W'($urandom);
    i_b   = W'($urandom);
    i_cin = 1'($urandom);
    i_sub = 1'($urandom);
  endtask

  // Single operation into an empty pipe; measures latency and the result.
  task automatic one_shot(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
    int           lat;
    logic [W+1:0] e;
    e       = ref_model(a, b, cin, sub);
    i_a     = a;
    i_b     = b;
    i_cin   = cin;
    i_sub   = sub;
    i_valid = 1'b1;
    i_ready = 1'b1;
    #1;
    check_eq({tag, "_rdy"}, 64'(o_ready), 64'(1));
    @(posedge clock);
    #1;
    i_valid = 1'b0;
    drive_junk();
    #1;
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(posedge clock);
      #2;
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(ST));
    check_eq({tag, "_sum"}, 64'(o_sum), 64'(e[W:0]));
`ifdef CSLA_PIPE_OVF_EN
    check_eq({tag, "_ovf"}, 64'(o_ovf), 64'(e[W+1]));
`endif
    @(posedge clock);
    #2;
    check_eq({tag, "_once"}, 64'(o_valid), 64'(0));
    @(posedge clock);
    #1;
  endtask

  // mode 0: valid always offered, i_ready toggles every 3 cycles; mode 1: random both.
  task automatic run_stream(input string tag, input int n, input int mode);
    int           sent, cyc, got0;
    logic         hold, acc;
    logic [W-1:0] ca, cb;
    logic         cc, cs;
    sent = 0;
    cyc  = 0;
    hold = 1'b0;
    got0 = n_got;
    while ((sent < n || exp_q.size() != 0) && cyc < 400) begin
      i_ready = (mode == 0) ? (((cyc / 3) % 2) == 0) : ($urandom_range(0, 9) < 6);
      if (sent < n && (mode == 0 || hold || $urandom_range(0, 9) < 7)) begin
        if (!hold) begin
          ca = pick_operand();
          cb = pick_operand();
          cc = 1'($urandom);
          cs = 1'($urandom);
        end
        hold    = 1'b1;
        i_valid = 1'b1;
        i_a     = ca;
        i_b     = cb;
        i_cin   = cc;
        i_sub   = cs;
      end else begin
        i_valid = 1'b0;
        drive_junk();
      end
      cycle_step(acc);
      if (acc) begin
        sent++;
        hold = 1'b0;
      end
      cyc++;
    end
    check_eq({tag, "_sent"}, 64'(sent), 64'(n));
    check_eq({tag, "_drained"}, 64'(n_got - got0), 64'(n));
    i_valid = 1'b0;
    i_ready = 1'b1;
  endtask

  // Sweep instances: WIDTH=32, BLOCK=4, STAGES=1..8, i_ready tied high.
  logic         sw_valid;
  logic [W-1:0] sw_a;
  logic [W-1:0] sw_b;
  logic         sw_cin;
  logic         sw_sub;
  logic         sw_on;
  int           sw_j;
  logic [W+1:0] sw_exp [SW_N];
  logic         sw_rdy [8];
  logic         sw_ov  [8];
  logic [W:0]   sw_sum [8];
`ifdef CSLA_PIPE_OVF_EN
  logic         sw_ovf [8];
`endif

  for (genvar g = 0; g < 8; g++) begin : g_sw
    localparam int SST = g + 1;

    csla_pipe_adder #(.WIDTH(W), .BLOCK(4), .STAGES(SST)) u_sw (
      .clock   (clock),
      .reset   (reset),
      .i_valid (sw_valid),
      .o_ready (sw_rdy[g]),
      .i_a     (sw_a),
      .i_b     (sw_b),
      .i_cin   (sw_cin),
      .i_sub   (sw_sub),
      .o_valid (sw_ov[g]),
      .i_ready (1'b1),
      .o_sum   (sw_sum[g])
`ifdef CSLA_PIPE_OVF_EN
      ,
      .o_ovf   (sw_ovf[g])
`endif
    );

    // Op presented in cycle j must be visible exactly in cycle j+SST.
    always @(negedge clock) begin : p_chk
      int k;
      if (sw_on) begin
        k = sw_j - SST;
        check_eq($sformatf("sw%0d_rdy", SST), 64'(sw_rdy[g]), 64'(1));
        if (k >= 0 && k < SW_N) begin
          check_eq($sformatf("sw%0d_valid", SST), 64'(sw_ov[g]), 64'(1));
          check_eq($sformatf("sw%0d_sum", SST), 64'(sw_sum[g]), 64'(sw_exp[k][W:0]));
`ifdef CSLA_PIPE_OVF_EN
          check_eq($sformatf("sw%0d_ovf", SST), 64'(sw_ovf[g]), 64'(sw_exp[k][W+1]));
`endif
        end else begin
          check_eq($sformatf("sw%0d_idle", SST), 64'(sw_ov[g]), 64'(0));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    reset      = 1'b1;
    i_valid    = 1'b0;
    i_ready    = 1'b1;
    i_a        = '0;
    i_b        = '0;
    i_cin      = 1'b0;
    i_sub      = 1'b0;
    sw_valid   = 1'b0;
    sw_a       = '0;
    sw_b       = '0;
    sw_cin     = 1'b0;
    sw_sub     = 1'b0;
    sw_on      = 1'b0;
    sw_j       = 0;
    occ        = 0;
    n_got      = 0;
    prev_stall = 1'b0;
    prev_sum   = '0;

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #2;
      check_eq("rst_valid", 64'(o_valid), 64'(0));
      check_eq("rst_sum", 64'(o_sum), 64'(0));
      check_eq("rst_ready", 64'(o_ready), 64'(0));
    end
    reset = 1'b0;
    #1;
    check_eq("post_rst_ready", 64'(o_ready), 64'(1));
    check_eq("post_rst_valid", 64'(o_valid), 64'(0));
    @(posedge clock);
    #1;

    // Directed arithmetic and boundary cases.
    one_shot("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    one_shot("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1);
    one_shot("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1);
    one_shot("sub_bin", 32'd7, 32'd5, 1'b1, 1'b1);
    one_shot("add_cin", 32'h1234_5678, 32'h0FED_CBA8, 1'b1, 1'b0);
    one_shot("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    one_shot("ovf_neg", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    one_shot("no_ovf", 32'd3, 32'd4, 1'b0, 1'b0);

    // Back-pressured stream, then fully random handshake traffic.
    run_stream("toggle", 10, 0);
    run_stream("random", 80, 1);

    // Reset with two results in flight: nothing may emerge afterwards.
    i_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_valid = 1'b1;
      i_a     = pick_operand();
      i_b     = pick_operand();
      i_cin   = 1'($urandom);
      i_sub   = 1'($urandom);
      cycle_step(acc);
      check_eq("fill_accept", 64'(acc), 64'(1));
    end
    i_valid = 1'b0;
    cycle_step(acc);
    reset = 1'b1;
    @(posedge clock);
    #2;
    check_eq("midrst_valid", 64'(o_valid), 64'(0));
    check_eq("midrst_ready", 64'(o_ready), 64'(0));
    reset = 1'b0;
    exp_q.delete();
    occ        = 0;
    prev_stall = 1'b0;
    i_ready    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #2;
      check_eq("midrst_stale", 64'(o_valid), 64'(0));
    end
    @(posedge clock);
    #1;

    // Pipeline depth sweep.
    sw_on = 1'b1;
    for (int j = 0; j < SW_N + 10; j++) begin
      sw_j = j;
      if (j < SW_N) begin
        sw_valid  = 1'b1;
        sw_a      = pick_operand();
        sw_b      = pick_operand();
        sw_cin    = 1'($urandom);
        sw_sub    = 1'($urandom);
        sw_exp[j] = ref_model(sw_a, sw_b, sw_cin, sw_sub);
      end else begin
        sw_valid = 1'b0;
        sw_a     = W'($urandom);
        sw_b     = W'($urandom);
      end
      @(posedge clock);
      #1;
    end
    sw_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
